// File: rtl/lsu_wb_master.sv
// ---------------------------------------------------------------------------
// lsu_wb_master
//
// Load/store unit sitting between the core's data port and a Wishbone RAM
// slave that only understands full 32-bit words.
//
//  * Loads (byte/half/word) and word stores each take a single bus cycle.
//  * Byte/half stores take a read-modify-write sequence:
//      read the word, merge the new low lane(s), idle the bus for one cycle,
//      then write the merged word back.
//  * Load data is sign- or zero-extended and held on Core_rdata until the
//    next load completes. Stores never touch Core_rdata.
//  * With CHECK_ALIGN=1, misaligned half/word accesses are rejected with a
//    one-cycle Core_err pulse and no bus cycle at all.
//
// The byte/half lane is always the low lane of the bus word. The bus address
// is the latched core address, passed through unmodified.
//
// Parameters
//   ADDR_W        byte-address width
//   CHECK_ALIGN   1: reject misaligned half/word accesses; 0: pass them on
//
// Ports
//   Clk            clock
//   Rst            synchronous reset, active-high (aborts any access)
//   Core_req       request strobe, sampled only while idle
//   Core_we        1 store, 0 load
//   Core_size      0 byte, 1 half, 2/3 word
//   Core_unsigned  load zero-extend (1) / sign-extend (0)
//   Core_addr      byte address
//   Core_wdata     store data (low lanes used for byte/half)
//   Core_rdata     extended load data
//   Core_done      1-cycle pulse: access complete
//   Core_err       1-cycle pulse: misaligned access rejected
//   Core_busy      unit is not idle
//   Wb_addr        bus address (registered)
//   Wb_cs          bus select (registered)
//   Wb_we          bus write enable (registered)
//   Wb_wdata       bus write data (registered)
//   Wb_rdata       bus read data, valid while Wb_ack=1
//   Wb_ack         slave acknowledge, 1-cycle pulse
// ---------------------------------------------------------------------------
module lsu_wb_master #(
  parameter int unsigned ADDR_W      = 32,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst,
  // core side
  input  logic              Core_req,
  input  logic              Core_we,
  input  logic [1:0]        Core_size,
  input  logic              Core_unsigned,
  input  logic [ADDR_W-1:0] Core_addr,
  input  logic [31:0]       Core_wdata,
  output logic [31:0]       Core_rdata,
  output logic              Core_done,
  output logic              Core_err,
  output logic              Core_busy,
  // Wishbone side
  output logic [ADDR_W-1:0] Wb_addr,
  output logic              Wb_cs,
  output logic              Wb_we,
  output logic [31:0]       Wb_wdata,
  input  logic [31:0]       Wb_rdata,
  input  logic              Wb_ack
);

  typedef enum logic [2:0] {
    ST_IDLE,    // waiting for Core_req
    ST_ACCESS,  // single bus cycle: load or word store
    ST_RMW_RD,  // read half of a byte/half store
    ST_GAP,     // mandatory idle bus cycle between RMW read and write
    ST_RMW_WR,  // write-back half of a byte/half store
    ST_ERR      // misaligned request, report and return to idle
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;

  // -------------------------------------------------------------------------
  // State and latched request
  // -------------------------------------------------------------------------
  state_e              state_q,    state_d;
  logic                we_q,       we_d;
  logic [1:0]          size_q,     size_d;
  logic                uns_q,      uns_d;
  logic [15:0]         wdata_lo_q, wdata_lo_d;  // only lanes an RMW merge needs

  // Registered outputs
  logic [ADDR_W-1:0]   wb_addr_q,  wb_addr_d;
  logic                wb_cs_q,    wb_cs_d;
  logic                wb_we_q,    wb_we_d;
  logic [31:0]         wb_wdata_q, wb_wdata_d;
  logic [31:0]         rdata_q,    rdata_d;
  logic                done_q,     done_d;
  logic                err_q,      err_d;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  // Sign/zero-extend the low byte/half of a bus word. Size 3 falls through
  // to the word case, so it behaves exactly like size 2.
  function automatic logic [31:0] extend_load(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [31:0] raw);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}},  raw[7:0]};
      SZ_HALF: res = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Alignment is judged on the incoming request; size[1] covers sizes 2 and 3.
  logic req_half;
  logic req_word;
  logic req_misaligned;

  assign req_half       = (Core_size == SZ_HALF);
  assign req_word       = Core_size[1];
  assign req_misaligned = CHECK_ALIGN &&
                          ((req_half && Core_addr[0]) ||
                           (req_word && (Core_addr[1:0] != 2'b00)));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    state_d    = state_q;
    we_d       = we_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wdata_lo_d = wdata_lo_q;
    wb_addr_d  = wb_addr_q;
    wb_cs_d    = wb_cs_q;
    wb_we_d    = wb_we_q;
    wb_wdata_d = wb_wdata_q;
    rdata_d    = rdata_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Core_req is only looked at here; requests while busy are dropped.
        if (Core_req) begin
          we_d       = Core_we;
          size_d     = Core_size;
          uns_d      = Core_unsigned;
          wdata_lo_d = Core_wdata[15:0];
          wb_addr_d  = Core_addr;
          if (req_misaligned) begin
            state_d = ST_ERR;
          end else if (!Core_we || req_word) begin
            state_d    = ST_ACCESS;
            wb_cs_d    = 1'b1;
            wb_we_d    = Core_we;
            wb_wdata_d = Core_wdata;
          end else begin
            // Sub-word store: fetch the surrounding word first.
            state_d = ST_RMW_RD;
            wb_cs_d = 1'b1;
            wb_we_d = 1'b0;
          end
        end
      end

      ST_ACCESS: begin
        if (Wb_ack) begin
          state_d = ST_IDLE;
          wb_cs_d = 1'b0;
          wb_we_d = 1'b0;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = extend_load(size_q, uns_q, Wb_rdata);
          end
        end
      end

      ST_RMW_RD: begin
        if (Wb_ack) begin
          state_d = ST_GAP;
          wb_cs_d = 1'b0;
          // Only byte/half stores get here; replace the low lane(s).
          if (size_q == SZ_BYTE) begin
            wb_wdata_d = {Wb_rdata[31:8], wdata_lo_q[7:0]};
          end else begin
            wb_wdata_d = {Wb_rdata[31:16], wdata_lo_q};
          end
        end
      end

      ST_GAP: begin
        // The bus must see Wb_cs low for a cycle between the two transfers.
        state_d = ST_RMW_WR;
        wb_cs_d = 1'b1;
        wb_we_d = 1'b1;
      end

      ST_RMW_WR: begin
        if (Wb_ack) begin
          state_d = ST_IDLE;
          wb_cs_d = 1'b0;
          wb_we_d = 1'b0;
          done_d  = 1'b1;
        end
      end

      ST_ERR: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
        wb_cs_d = 1'b0;
        wb_we_d = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'd0;
      uns_q      <= 1'b0;
      wdata_lo_q <= 16'h0;
      wb_addr_q  <= '0;
      wb_cs_q    <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_wdata_q <= 32'h0;
      rdata_q    <= 32'h0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wdata_lo_q <= wdata_lo_d;
      wb_addr_q  <= wb_addr_d;
      wb_cs_q    <= wb_cs_d;
      wb_we_q    <= wb_we_d;
      wb_wdata_q <= wb_wdata_d;
      rdata_q    <= rdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign Core_rdata = rdata_q;
  assign Core_done  = done_q;
  assign Core_err   = err_q;
  assign Core_busy  = (state_q != ST_IDLE);
  assign Wb_addr    = wb_addr_q;
  assign Wb_cs      = wb_cs_q;
  assign Wb_we      = wb_we_q;
  assign Wb_wdata   = wb_wdata_q;

endmodule

// File: tb/tb_lsu_wb_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_wb_master
//
// Directed bench for lsu_wb_master. A small Wishbone RAM model answers each
// bus cycle with a registered one-cycle ack (reads data, writes on the
// first cs cycle). Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_lsu_wb_master;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        Core_req = 1'b0;
  logic        Core_we = 1'b0;
  logic [1:0]  Core_size = 2'd0;
  logic        Core_unsigned = 1'b0;
  logic [31:0] Core_addr = 32'h0;
  logic [31:0] Core_wdata = 32'h0;
  logic [31:0] Core_rdata;
  logic        Core_done;
  logic        Core_err;
  logic        Core_busy;
  logic [31:0] Wb_addr;
  logic        Wb_cs;
  logic        Wb_we;
  logic [31:0] Wb_wdata;
  logic [31:0] Wb_rdata;
  logic        Wb_ack;

  int checks   = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  lsu_wb_master #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .Core_req     (Core_req),
    .Core_we      (Core_we),
    .Core_size    (Core_size),
    .Core_unsigned(Core_unsigned),
    .Core_addr    (Core_addr),
    .Core_wdata   (Core_wdata),
    .Core_rdata   (Core_rdata),
    .Core_done    (Core_done),
    .Core_err     (Core_err),
    .Core_busy    (Core_busy),
    .Wb_addr      (Wb_addr),
    .Wb_cs        (Wb_cs),
    .Wb_we        (Wb_we),
    .Wb_wdata     (Wb_wdata),
    .Wb_rdata     (Wb_rdata),
    .Wb_ack       (Wb_ack)
  );

  // Wishbone RAM model: 64 words, ack one cycle after cs rises.
  logic [31:0] mem [0:63];

  always @(posedge Clk) begin
    if (Rst) begin
      Wb_ack   <= 1'b0;
      Wb_rdata <= 32'h0;
    end else begin
      Wb_ack <= Wb_cs & ~Wb_ack;
      if (Wb_cs && !Wb_ack) begin
        Wb_rdata <= mem[Wb_addr[7:2]];
        if (Wb_we) mem[Wb_addr[7:2]] <= Wb_wdata;
      end
    end
  end

  // Bus monitor, sampled mid-cycle.
  int   cs_rises = 0;
  int   gap_viol = 0;
  int   done_cnt = 0;
  logic prev_cs  = 1'b0;
  logic prev_ack = 1'b0;

  always @(negedge Clk) begin
    if (Wb_cs && !prev_cs) cs_rises <= cs_rises + 1;
    if (prev_ack && Wb_cs) gap_viol <= gap_viol + 1;
    if (Core_done)         done_cnt <= done_cnt + 1;
    prev_cs  <= Wb_cs;
    prev_ack <= Wb_cs & Wb_ack;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and count edges after the sampling edge until
  // Core_done or Core_err is seen (-1 on timeout).
  task automatic do_access(input logic at_neg, input logic we, input logic [1:0] sz,
                           input logic uns, input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output logic got_err);
    if (at_neg) @(negedge Clk);
    Core_req      = 1'b1;
    Core_we       = we;
    Core_size     = sz;
    Core_unsigned = uns;
    Core_addr     = a;
    Core_wdata    = wd;
    @(posedge Clk);
    #1 Core_req = 1'b0;
    lat     = -1;
    got_err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge Clk);
      #1;
      if (Core_done || Core_err) begin
        lat     = n;
        got_err = Core_err;
        break;
      end
    end
  endtask

  int   lat;
  logic e;
  int   c0;
  int   d0;

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_ctrl", {27'h0, Core_done, Core_err, Core_busy, Wb_cs, Wb_we}, 32'h0);
    check("rst_rdata", Core_rdata, 32'h0);
    check("rst_wdata", Wb_wdata, 32'h0);
    check("rst_addr", Wb_addr, 32'h0);
    Rst = 1'b0;

    // ---------------- word store / word load ----------------
    c0 = cs_rises;
    do_access(1, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, lat, e);
    check("wst_lat", lat, 2);
    check("wst_mem", mem[4], 32'hDEADBEEF);
    check("wst_rdata_kept", Core_rdata, 32'h0);
    check("wst_cs_once", cs_rises - c0, 1);
    do_access(1, 0, 2'd2, 0, 32'h10, 32'h0, lat, e);
    check("wld_lat", lat, 2);
    check("wld_rdata", Core_rdata, 32'hDEADBEEF);

    // ---------------- byte store read-modify-write ----------------
    do_access(1, 1, 2'd2, 0, 32'h10, 32'h11223344, lat, e);
    c0 = cs_rises;
    do_access(1, 1, 2'd0, 0, 32'h11, 32'hFFFFFFA5, lat, e);
    check("bst_lat", lat, 5);
    check("bst_mem", mem[4], 32'h112233A5);
    check("bst_two_cycles", cs_rises - c0, 2);
    check("bst_rdata_kept", Core_rdata, 32'hDEADBEEF);
    do_access(1, 0, 2'd2, 0, 32'h10, 32'h0, lat, e);
    check("bst_readback", Core_rdata, 32'h112233A5);

    // ---------------- load extension ----------------
    do_access(1, 1, 2'd2, 0, 32'h20, 32'h12345680, lat, e);
    do_access(1, 1, 2'd2, 0, 32'h24, 32'hCAFE8001, lat, e);
    do_access(1, 0, 2'd0, 0, 32'h20, 32'h0, lat, e);
    check("lb_signed", Core_rdata, 32'hFFFFFF80);
    do_access(1, 0, 2'd0, 1, 32'h20, 32'h0, lat, e);
    check("lb_unsigned", Core_rdata, 32'h00000080);
    do_access(1, 0, 2'd1, 0, 32'h20, 32'h0, lat, e);
    check("lh_signed_pos", Core_rdata, 32'h00005680);
    do_access(1, 0, 2'd1, 0, 32'h24, 32'h0, lat, e);
    check("lh_signed", Core_rdata, 32'hFFFF8001);
    check("lh_lat", lat, 2);
    do_access(1, 0, 2'd1, 1, 32'h24, 32'h0, lat, e);
    check("lh_unsigned", Core_rdata, 32'h00008001);
    do_access(1, 0, 2'd0, 0, 32'h24, 32'h0, lat, e);
    check("lb_signed_pos", Core_rdata, 32'h00000001);
    do_access(1, 0, 2'd3, 1, 32'h24, 32'h0, lat, e);
    check("lw_size3", Core_rdata, 32'hCAFE8001);

    // ---------------- misaligned ----------------
    c0 = cs_rises;
    do_access(1, 0, 2'd1, 0, 32'h21, 32'h0, lat, e);
    check("mis_lh_lat", lat, 1);
    check("mis_lh_err", {31'h0, e}, 32'h1);
    check("mis_lh_rdata", Core_rdata, 32'hCAFE8001);
    do_access(1, 1, 2'd2, 0, 32'h22, 32'h0, lat, e);
    check("mis_sw_err", {31'h0, e}, 32'h1);
    check("mis_sw_lat", lat, 1);
    do_access(1, 1, 2'd3, 0, 32'h26, 32'h0, lat, e);
    check("mis_s3_err", {31'h0, e}, 32'h1);
    check("mis_no_cs", cs_rises - c0, 0);
    check("mis_mem", mem[8], 32'h12345680);
    check("mis_rdata_kept", Core_rdata, 32'hCAFE8001);

    // ---------------- request while busy is ignored ----------------
    c0 = cs_rises;
    @(negedge Clk);
    Core_req = 1'b1; Core_we = 1'b0; Core_size = 2'd2; Core_addr = 32'h10;
    @(posedge Clk);
    #1;
    check("busy_flag", {31'h0, Core_busy}, 32'h1);
    Core_we = 1'b1; Core_addr = 32'h30; Core_wdata = 32'h0BADF00D;
    @(posedge Clk);
    #1 Core_req = 1'b0;
    lat = -1;
    for (int n = 2; n <= 20; n++) begin
      @(posedge Clk);
      #1;
      if (Core_done) begin
        lat = n;
        break;
      end
    end
    repeat (3) @(posedge Clk);
    check("busy_lat", lat, 2);
    check("busy_rdata", Core_rdata, 32'h112233A5);
    check("busy_one_cycle", cs_rises - c0, 1);

    // ---------------- back-to-back on the done cycle ----------------
    do_access(1, 1, 2'd2, 0, 32'h30, 32'h55AA55AA, lat, e);
    check("b2b_first_lat", lat, 2);
    do_access(0, 0, 2'd2, 0, 32'h30, 32'h0, lat, e);
    check("b2b_second_lat", lat, 2);
    check("b2b_rdata", Core_rdata, 32'h55AA55AA);

    // ---------------- reset during RMW gap ----------------
    do_access(1, 1, 2'd2, 0, 32'h28, 32'hAABBCCDD, lat, e);
    @(negedge Clk);
    Core_req = 1'b1; Core_we = 1'b1; Core_size = 2'd1; Core_addr = 32'h28;
    Core_wdata = 32'h00001234;
    @(posedge Clk);
    #1 Core_req = 1'b0;
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    #2;
    check("gap_state", {30'h0, Core_busy, Wb_cs}, 32'h2);
    d0 = done_cnt;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    check("abort_ctrl", {29'h0, Core_busy, Wb_cs, Core_done}, 32'h0);
    check("abort_rdata", Core_rdata, 32'h0);
    @(negedge Clk);
    Rst = 1'b0;
    repeat (6) @(negedge Clk);
    #2;
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_mem", mem[10], 32'hAABBCCDD);
    do_access(1, 1, 2'd1, 0, 32'h28, 32'hFFFF1234, lat, e);
    check("after_rst_lat", lat, 5);
    check("after_rst_mem", mem[10], 32'hAABB1234);
    do_access(1, 0, 2'd2, 0, 32'h28, 32'h0, lat, e);
    check("after_rst_load", Core_rdata, 32'hAABB1234);

    // ---------------- bus idle rule over the whole run ----------------
    repeat (2) @(negedge Clk);
    #2;
    check("bus_gap_rule", gap_viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
